// File: rtl/mux_scan_ctrl.sv
`timescale 1ns/1ps
// mux_scan_ctrl: walks the 4:1 mux select through 00..11, holds each code
// for DWELL cycles, samples mux_y at the end of each window and publishes
// the packed 4-bit result with a one-cycle valid pulse.
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       mux_y,
  output logic [1:0] sel,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  sh_q, sh_d;
  logic [3:0]  sample_q, sample_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  // State register; reset discards any partial scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 2'b00;
      cnt_q    <= 8'd0;
      sh_q     <= 3'b000;
      sample_q <= 4'b0000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state: dwell counting, per-window capture and scan completion.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        sel_d = 2'b00;
        cnt_d = 8'd0;
        if (start) begin
          state_d = SCAN;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (sel_q != 2'b11) begin
            // Intermediate windows park their sample in the shadow bits.
            sh_d[sel_q] = mux_y;
            sel_d       = sel_q + 2'b01;
          end else begin
            // Last cycle of the scan: publish and decide whether to rescan.
            sample_d = {mux_y, sh_q};
            valid_d  = 1'b1;
            sel_d    = 2'b00;
            if (!mode) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel    = sel_q;
  assign sample = sample_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for mux_scan_ctrl: three DUTs (DWELL = 4, 2, 1) each driven by its
// own stimulus process; expected results are queued at scan issue and popped
// by an independent per-cycle monitor.
module tb_mux_scan_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] s;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done [3];
  bit   stop = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int D = (g == 0) ? 4 : (g == 1) ? 2 : 1;

    logic       rst, start, mode, mux_y, valid, busy;
    logic [3:0] in, sample;
    logic [1:0] sel;
    exp_t       q[$];
    bit   [1:0] exp_sel [int];
    bit         exp_busy [int];
    logic [3:0] cur_exp = 4'b0000;
    bit         rst_seen = 1'b0;

    // External 4:1 mux driven by the DUT's registered select.
    assign mux_y = in[sel];

    mux_scan_ctrl #(.DWELL(D)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .mux_y(mux_y),
      .sel(sel), .sample(sample), .valid(valid), .busy(busy)
    );

    // One start request followed by nscan scans; glitch: 0 hold, 1 invert,
    // 2 random between capture points; rst_at: relative cycle of reset (0=none).
    task automatic run(input int nscan, input logic [15:0] fv, input bit use_fv,
                       input int glitch, input int rst_at);
      int         c0, j, r, w;
      logic [3:0] v [4];
      c0 = cyc;
      for (int k = 0; k < 4; k++) v[k] = use_fv ? fv[4*k +: 4] : 4'($urandom);
      for (int k = 0; k < nscan; k++)
        if (rst_at == 0 || rst_at > 4*D*(k+1))
          q.push_back('{c0 + 4*D*(k+1) + 1, v[k]});
      start = 1'b1;
      mode  = 1'($urandom);
      in    = 4'($urandom);
      for (int t = 1; t <= 4*D*nscan; t++) begin
        @(posedge clk); #1;
        j = (t - 1) / (4*D);
        r = t - 4*D*j;
        w = (r - 1) / D;
        exp_sel[c0 + t]  = 2'(w);
        exp_busy[c0 + t] = 1'b1;
        start = (r == 3 || r == 6) ? 1'b1 : 1'($urandom_range(0, 1));
        mode  = (r == 4*D) ? (j < nscan - 1) : 1'($urandom);
        in    = (glitch == 0) ? v[j] : (glitch == 1) ? ~v[j] : 4'($urandom);
        if (r % D == 0) in[w] = v[j][w];
        if (rst_at != 0 && t == rst_at) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst   = 1'b0;
          start = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      mode  = 1'($urandom);
      in    = 4'($urandom);
    endtask

    task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1'($urandom);
        in    = 4'($urandom);
      end
    endtask

    // Stimulus: directed cases for this DWELL, then randomized runs.
    initial begin
      int ns, ra;
      rst = 1'b1; start = 1'b0; mode = 1'b0; in = 4'b0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);
      if (D == 4) begin
        run(1, 16'h000D, 1'b1, 0, 0);   // a/b/c/d = 1/0/1/1
        idle(2);
        run(1, 16'h0000, 1'b1, 1, 0);   // glitching outside capture points
        idle(2);
        run(1, 16'h000F, 1'b1, 0, 10);  // reset mid-scan
        idle(2);
        run(1, 16'h0006, 1'b1, 0, 0);
        idle(1);
      end else if (D == 2) begin
        run(3, 16'h055A, 1'b1, 0, 0);   // 0/1/0/1, 1/0/1/0, then stop
        idle(2);
      end else begin
        run(1, 16'h000B, 1'b1, 0, 0);   // a/b/c/d = 1/1/0/1
        idle(2);
      end
      for (int i = 0; i < 15; i++) begin
        ns = $urandom_range(1, 3);
        ra = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4*D*ns) : 0;
        run(ns, 16'($urandom), 1'b0, 2, ra);
        idle($urandom_range(1, 3));
      end
      idle(4);
      chk($sformatf("D%0d pending valids", D), q.size(), 0);
      done[g] = 1'b1;
    end

    // Monitor: compare every registered output against the expectations.
    always @(negedge clk) begin
      bit exp_v;
      if (cyc >= 1 && !stop) begin
        if (rst_seen) cur_exp = 4'b0000;
        while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
        exp_v = (q.size() > 0 && q[0].cyc == cyc);
        chk($sformatf("D%0d valid c%0d", D, cyc), int'(valid), int'(exp_v));
        if (exp_v) cur_exp = q.pop_front().s;
        chk($sformatf("D%0d sample c%0d", D, cyc), int'(sample), int'(cur_exp));
        chk($sformatf("D%0d sel c%0d", D, cyc), int'(sel),
            exp_sel.exists(cyc) ? int'(exp_sel[cyc]) : 0);
        chk($sformatf("D%0d busy c%0d", D, cyc), int'(busy),
            exp_busy.exists(cyc) ? int'(exp_busy[cyc]) : 0);
        rst_seen = rst;
      end
    end
  end

  initial begin
    fork
      wait (done[0] && done[1] && done[2]);
      #200000;
    join_any
    disable fork;
    stop = 1'b1;
    chk("run completed", int'(done[0] && done[1] && done[2]), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
